mem_noc_arb: RTL and testbench
==============================

Name: mem_noc_arb

Overview:
- Single-clock N:1 arbiter sharing one mem_req_t/mem_resp_t valid/ready port (typically the src side of a cdc_mem_noc bridge) between N masters, e.g. ifetch and LSU.
- Round-robin request arbitration with grant lock until handshake.
- In-order response routing back to the issuing master via an ID order FIFO that bounds outstanding transactions.
- Slave contract: exactly one response per accepted request (read and write), in request order.

Parameters:
- N_MST, 2, number of masters (2..8).
- OUTSTD, 4, max outstanding requests; power of two, 2..16.
- ID_W, $clog2(N_MST) (min 1), width of stored master index (local, derived).

Ports:
- clk  in  1  block clock.
- rstn  in  1  asynchronous active-low reset.
- mst_req_valid  in  N_MST  per-master request valid.
- mst_req_ready  out  N_MST  per-master request ready.
- mst_req  in  N_MST x $bits(mem_req_t)  per-master request payload, packed array.
- mst_resp_valid  out  N_MST  per-master response valid.
- mst_resp_ready  in  N_MST  per-master response ready.
- mst_resp  out  $bits(mem_resp_t)  response payload, broadcast to all masters.
- slv_req_valid  out  1  request valid to shared port.
- slv_req_ready  in  1  shared port ready.
- slv_req  out  $bits(mem_req_t)  granted master's payload.
- slv_resp_valid  in  1  response valid from shared port.
- slv_resp_ready  out  1  response ready to shared port.
- slv_resp  in  $bits(mem_resp_t)  response payload.
- outstd_cnt  out  $clog2(OUTSTD)+1  current order-FIFO occupancy.

Behaviour:
- Reset (rstn low, async): rr_ptr=0, lock=0, lock_id=0, order FIFO empty, outstd_cnt=0.
- Outputs are combinational from state plus inputs. With all inputs idle after reset: slv_req_valid=0, mst_req_ready=0, mst_resp_valid=0, slv_resp_ready=0.
- Arbitration:
  - If lock=1, gnt=lock_id.
  - Otherwise gnt is the first index with mst_req_valid set, searching rr_ptr, rr_ptr+1, ... mod N_MST.
- slv_req_valid = mst_req_valid[gnt] && !fifo_full. slv_req = mst_req[gnt].
- mst_req_ready[i] = (i==gnt) && slv_req_ready && !fifo_full. All other masters see ready=0.
- Zero-cycle request path: no added latency master -> slave.
- Lock:
  - Set lock=1, lock_id=gnt when slv_req_valid && !slv_req_ready.
  - Clear on request handshake (slv_req_valid && slv_req_ready).
  - Guarantees the slave sees stable valid/payload under backpressure. Masters must not drop valid before handshake.
- On request handshake: push gnt into the order FIFO, set rr_ptr = (gnt+1) mod N_MST.
- fifo_full (cnt==OUTSTD) blocks acceptance, even if a pop occurs in the same cycle. Push and pop in the same cycle when not full: cnt unchanged.
- Response routing:
  - head = FIFO head ID.
  - mst_resp_valid[i] = slv_resp_valid && !fifo_empty && (i==head).
  - slv_resp_ready = !fifo_empty && mst_resp_ready[head].
  - mst_resp = slv_resp.
  - Pop on slv_resp_valid && slv_resp_ready.
- slv_resp_valid while FIFO empty is a protocol violation: slv_resp_ready held 0, nothing routed, state unchanged; simulation assertion fires.
- FIFO pointers are ID_W-wide entries of depth OUTSTD, wrap naturally mod OUTSTD; cnt is the separate occupancy counter.
- Reset mid-transaction discards all outstanding IDs. Slave and bridge must be reset together.
- Assertions: no push when full, no pop when empty, slv_req stable while valid && !ready.

Test Plan:
- Single master 0 read, slv_req_ready=1 -> slv_req_valid same cycle, outstd_cnt 0->1. Response returned -> mst_resp_valid=2'b01, outstd_cnt back to 0.
- Both masters valid continuously, slave always ready -> grants alternate 0,1,0,1. Responses route to IDs 0,1,0,1 in order.
- Master 1 granted, slv_req_ready held 0 for 3 cycles while master 0 also valid -> gnt stays 1 with stable slv_req; on handshake rr_ptr=0 and master 0 is granted next.
- OUTSTD=4, 4 requests accepted with no responses -> outstd_cnt=4, slv_req_valid=0. Response popped in the same cycle as a new request -> new request not accepted that cycle, accepted next.
- mst_resp_ready[head]=0 for 2 cycles -> slv_resp_ready=0, FIFO head unchanged. Then ready=1 -> single pop, next head routed.
- Reset asserted with outstd_cnt=3 -> outstd_cnt=0, all resp valids 0 immediately (async), rr_ptr=0 after release.

Source files
------------

// File: rtl/mem_noc_arb.sv
// mem_noc_arb: N:1 round-robin arbiter onto one shared mem_req_t/mem_resp_t
// valid/ready port. In-order responses are routed back to the issuing master
// through an ID order FIFO, which also bounds the number of outstanding requests.

package mem_noc_pkg;
  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } mem_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } mem_resp_t;

  localparam int REQ_W  = $bits(mem_req_t);
  localparam int RESP_W = $bits(mem_resp_t);
endpackage

module mem_noc_arb
  import mem_noc_pkg::*;
#(
  parameter int N_MST  = 2,
  parameter int OUTSTD = 4
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic [N_MST-1:0]                mst_req_valid,
  output logic [N_MST-1:0]                mst_req_ready,
  input  logic [N_MST-1:0][REQ_W-1:0]     mst_req,
  output logic [N_MST-1:0]                mst_resp_valid,
  input  logic [N_MST-1:0]                mst_resp_ready,
  output logic [RESP_W-1:0]               mst_resp,
  output logic                            slv_req_valid,
  input  logic                            slv_req_ready,
  output logic [REQ_W-1:0]                slv_req,
  input  logic                            slv_resp_valid,
  output logic                            slv_resp_ready,
  input  logic [RESP_W-1:0]               slv_resp,
  output logic [$clog2(OUTSTD):0]         outstd_cnt
);

  localparam int ID_W  = (N_MST > 1) ? $clog2(N_MST) : 1;
  localparam int PTR_W = $clog2(OUTSTD);
  localparam int CNT_W = PTR_W + 1;

  // Arbitration state
  logic [ID_W-1:0]  rr_ptr_reg;
  logic             lock_reg;
  logic [ID_W-1:0]  lock_id_reg;

  // Order FIFO state
  logic [ID_W-1:0]  fifo_mem [OUTSTD];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] cnt_reg;

  logic             fifo_full;
  logic             fifo_empty;
  logic [ID_W-1:0]  head;
  logic [ID_W-1:0]  gnt;
  logic [ID_W:0]    arb_idx;
  logic [ID_W-1:0]  rr_next;
  logic             push;
  logic             pop;

  assign fifo_full  = (cnt_reg == CNT_W'(OUTSTD));
  assign fifo_empty = (cnt_reg == '0);
  assign head       = fifo_mem[rd_ptr_reg];
  assign outstd_cnt = cnt_reg;

  // Grant selection: held master while locked, else first valid from rr_ptr upward
  always_comb begin
    gnt     = rr_ptr_reg;
    arb_idx = '0;
    // Walk offsets from the far end so the closest valid index wins last
    for (int k = N_MST - 1; k >= 0; k--) begin
      arb_idx = {1'b0, rr_ptr_reg} + (ID_W+1)'(k);
      if (arb_idx >= (ID_W+1)'(N_MST)) begin
        arb_idx = arb_idx - (ID_W+1)'(N_MST);
      end
      if (mst_req_valid[arb_idx[ID_W-1:0]]) begin
        gnt = arb_idx[ID_W-1:0];
      end
    end
    if (lock_reg) begin
      gnt = lock_id_reg;
    end
  end

  // Zero-latency request path; a full order FIFO stalls all acceptance
  assign slv_req_valid = mst_req_valid[gnt] && !fifo_full;
  assign slv_req       = mst_req[gnt];
  assign push          = slv_req_valid && slv_req_ready;

  // Responses go to the FIFO head; an empty FIFO never accepts a response
  assign slv_resp_ready = !fifo_empty && mst_resp_ready[head];
  assign mst_resp       = slv_resp;
  assign pop            = slv_resp_valid && slv_resp_ready;

  assign rr_next = (gnt == ID_W'(N_MST - 1)) ? '0 : gnt + 1'b1;

  generate
    for (genvar gi = 0; gi < N_MST; gi++) begin : g_mst
      assign mst_req_ready[gi]  = (gnt == ID_W'(gi)) && slv_req_ready && !fifo_full;
      assign mst_resp_valid[gi] = slv_resp_valid && !fifo_empty && (head == ID_W'(gi));
    end
  endgenerate

  // Round-robin pointer and grant lock held across slave backpressure
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rr_ptr_reg  <= '0;
      lock_reg    <= 1'b0;
      lock_id_reg <= '0;
    end else begin
      if (push) begin
        rr_ptr_reg <= rr_next;
        lock_reg   <= 1'b0;
      end else if (slv_req_valid && !slv_req_ready) begin
        lock_reg    <= 1'b1;
        lock_id_reg <= gnt;
      end
    end
  end

  // Order FIFO pointers and occupancy counter
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      cnt_reg    <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   cnt_reg <= cnt_reg + 1'b1;
        2'b01:   cnt_reg <= cnt_reg - 1'b1;
        default: cnt_reg <= cnt_reg;
      endcase
    end
  end

  // Order FIFO storage: records which master issued each accepted request
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= gnt;
    end
  end

  a_no_push_full: assert property (@(posedge clk) disable iff (!rstn)
    !(push && fifo_full));
  a_no_pop_empty: assert property (@(posedge clk) disable iff (!rstn)
    !(pop && fifo_empty));
  a_no_resp_empty: assert property (@(posedge clk) disable iff (!rstn)
    !(slv_resp_valid && fifo_empty));
  a_req_stable: assert property (@(posedge clk) disable iff (!rstn)
    (slv_req_valid && !slv_req_ready) |=> (slv_req_valid && $stable(slv_req)));

endmodule

// File: tb/tb_mem_noc_arb.sv
// Directed bench for mem_noc_arb with N_MST=2, OUTSTD=4.
module tb_mem_noc_arb;
  import mem_noc_pkg::*;

  logic                     clk;
  logic                     rstn;
  logic [1:0]               mst_req_valid;
  logic [1:0]               mst_req_ready;
  logic [1:0][REQ_W-1:0]    mst_req;
  logic [1:0]               mst_resp_valid;
  logic [1:0]               mst_resp_ready;
  logic [RESP_W-1:0]        mst_resp;
  logic                     slv_req_valid;
  logic                     slv_req_ready;
  logic [REQ_W-1:0]         slv_req;
  logic                     slv_resp_valid;
  logic                     slv_resp_ready;
  logic [RESP_W-1:0]        slv_resp;
  logic [2:0]               outstd_cnt;

  int checks;
  int failures;

  mem_req_t  r0;
  mem_req_t  r1;
  mem_resp_t p0;
  mem_resp_t p1;
  mem_resp_t p2;
  mem_resp_t p3;

  mem_noc_arb #(.N_MST(2), .OUTSTD(4)) dut (
    .clk            (clk),
    .rstn           (rstn),
    .mst_req_valid  (mst_req_valid),
    .mst_req_ready  (mst_req_ready),
    .mst_req        (mst_req),
    .mst_resp_valid (mst_resp_valid),
    .mst_resp_ready (mst_resp_ready),
    .mst_resp       (mst_resp),
    .slv_req_valid  (slv_req_valid),
    .slv_req_ready  (slv_req_ready),
    .slv_req        (slv_req),
    .slv_resp_valid (slv_resp_valid),
    .slv_resp_ready (slv_resp_ready),
    .slv_resp       (slv_resp),
    .outstd_cnt     (outstd_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    r0 = '{we: 1'b0, addr: 32'h0000_1000, wdata: 32'h0,         be: 4'hf};
    r1 = '{we: 1'b1, addr: 32'h0000_2004, wdata: 32'hcafe_f00d, be: 4'h3};
    p0 = '{rdata: 32'h1111_aaaa, err: 1'b0};
    p1 = '{rdata: 32'h2222_bbbb, err: 1'b0};
    p2 = '{rdata: 32'h3333_cccc, err: 1'b1};
    p3 = '{rdata: 32'h4444_dddd, err: 1'b0};

    rstn           = 1'b0;
    mst_req_valid  = 2'b00;
    mst_req[0]     = r0;
    mst_req[1]     = r1;
    mst_resp_ready = 2'b00;
    slv_req_ready  = 1'b0;
    slv_resp_valid = 1'b0;
    slv_resp       = '0;

    // Reset state
    #2;
    chk("rst_cnt",        128'(outstd_cnt), 128'(0));
    chk("rst_slv_valid",  128'(slv_req_valid), 128'(0));
    chk("rst_mst_ready",  128'(mst_req_ready), 128'(0));
    chk("rst_resp_valid", 128'(mst_resp_valid), 128'(0));
    chk("rst_resp_ready", 128'(slv_resp_ready), 128'(0));
    cyc();
    rstn = 1'b1;

    // Single master-0 read, zero-cycle request path
    mst_req_valid = 2'b01;
    slv_req_ready = 1'b1;
    #1;
    chk("t1_slv_valid", 128'(slv_req_valid), 128'(1));
    chk("t1_slv_req",   128'(slv_req), 128'(r0));
    chk("t1_mst_ready", 128'(mst_req_ready), 128'(2'b01));
    cyc();
    mst_req_valid = 2'b00;
    #1;
    chk("t1_cnt1", 128'(outstd_cnt), 128'(1));
    slv_resp_valid = 1'b1;
    slv_resp       = p0;
    mst_resp_ready = 2'b11;
    #1;
    chk("t1_resp_valid", 128'(mst_resp_valid), 128'(2'b01));
    chk("t1_resp_ready", 128'(slv_resp_ready), 128'(1));
    chk("t1_resp_data",  128'(mst_resp), 128'(p0));
    cyc();
    slv_resp_valid = 1'b0;
    #1;
    chk("t1_cnt0", 128'(outstd_cnt), 128'(0));

    // Both masters valid, slave always ready: grants alternate (rr_ptr is 1 here)
    mst_req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("t2_gnt_ready", 128'(mst_req_ready), 128'((k % 2 == 0) ? 2'b10 : 2'b01));
      chk("t2_gnt_req",   128'(slv_req), 128'((k % 2 == 0) ? r1 : r0));
      cyc();
    end

    // FIFO full: acceptance blocked, also when a pop happens in the same cycle
    #1;
    chk("t4_cnt_full",   128'(outstd_cnt), 128'(4));
    chk("t4_full_valid", 128'(slv_req_valid), 128'(0));
    chk("t4_full_ready", 128'(mst_req_ready), 128'(0));
    slv_resp_valid = 1'b1;
    slv_resp       = p1;
    #1;
    chk("t4_pop_route",  128'(mst_resp_valid), 128'(2'b10));
    chk("t4_pop_ready",  128'(slv_resp_ready), 128'(1));
    chk("t4_pop_block",  128'(mst_req_ready), 128'(0));
    cyc();
    slv_resp_valid = 1'b0;
    #1;
    chk("t4_cnt3",        128'(outstd_cnt), 128'(3));
    chk("t4_accept_next", 128'(mst_req_ready), 128'(2'b10));
    cyc();
    mst_req_valid = 2'b00;
    #1;
    chk("t4_cnt_refill", 128'(outstd_cnt), 128'(4));

    // Response backpressure at head (head=0, FIFO 0,1,0,1)
    slv_resp_valid = 1'b1;
    slv_resp       = p2;
    mst_resp_ready = 2'b10;
    #1;
    chk("t5_bp_valid", 128'(mst_resp_valid), 128'(2'b01));
    chk("t5_bp_ready", 128'(slv_resp_ready), 128'(0));
    cyc();
    chk("t5_bp_cnt_a",  128'(outstd_cnt), 128'(4));
    chk("t5_bp_head_a", 128'(mst_resp_valid), 128'(2'b01));
    cyc();
    chk("t5_bp_cnt_b",  128'(outstd_cnt), 128'(4));
    mst_resp_ready = 2'b11;
    #1;
    chk("t5_release_ready", 128'(slv_resp_ready), 128'(1));
    cyc();
    chk("t5_cnt3",  128'(outstd_cnt), 128'(3));
    chk("t5_head1", 128'(mst_resp_valid), 128'(2'b10));
    cyc();
    chk("t5_cnt2",  128'(outstd_cnt), 128'(2));
    chk("t5_head0", 128'(mst_resp_valid), 128'(2'b01));
    cyc();
    chk("t5_cnt1",  128'(outstd_cnt), 128'(1));
    chk("t5_head1b", 128'(mst_resp_valid), 128'(2'b10));
    cyc();
    chk("t5_cnt0",        128'(outstd_cnt), 128'(0));
    chk("t5_empty_valid", 128'(mst_resp_valid), 128'(2'b00));
    chk("t5_empty_ready", 128'(slv_resp_ready), 128'(0));
    slv_resp_valid = 1'b0;

    // Lock: master 1 granted under backpressure while master 0 joins (rr_ptr=0)
    slv_req_ready = 1'b0;
    mst_req_valid = 2'b10;
    #1;
    chk("t3_first_valid", 128'(slv_req_valid), 128'(1));
    chk("t3_first_req",   128'(slv_req), 128'(r1));
    chk("t3_first_ready", 128'(mst_req_ready), 128'(2'b00));
    cyc();
    mst_req_valid = 2'b11;
    for (int k = 0; k < 2; k++) begin
      #1;
      chk("t3_lock_req",   128'(slv_req), 128'(r1));
      chk("t3_lock_valid", 128'(slv_req_valid), 128'(1));
      chk("t3_lock_ready", 128'(mst_req_ready), 128'(2'b00));
      cyc();
    end
    slv_req_ready = 1'b1;
    #1;
    chk("t3_hs_ready", 128'(mst_req_ready), 128'(2'b10));
    chk("t3_hs_req",   128'(slv_req), 128'(r1));
    cyc();
    #1;
    chk("t3_next_ready", 128'(mst_req_ready), 128'(2'b01));
    chk("t3_next_req",   128'(slv_req), 128'(r0));
    cyc();
    mst_req_valid = 2'b01;
    #1;
    chk("t3_wrap_ready", 128'(mst_req_ready), 128'(2'b01));
    cyc();
    mst_req_valid = 2'b00;
    #1;
    chk("t3_cnt3", 128'(outstd_cnt), 128'(3));

    // Asynchronous reset with 3 outstanding (head=1, rr_ptr=1)
    slv_resp_valid = 1'b1;
    slv_resp       = p3;
    #1;
    chk("t6_pre_valid", 128'(mst_resp_valid), 128'(2'b10));
    rstn = 1'b0;
    #1;
    chk("t6_rst_cnt",   128'(outstd_cnt), 128'(0));
    chk("t6_rst_valid", 128'(mst_resp_valid), 128'(2'b00));
    chk("t6_rst_ready", 128'(slv_resp_ready), 128'(0));
    slv_resp_valid = 1'b0;
    cyc();
    rstn = 1'b1;
    mst_req_valid = 2'b11;
    #1;
    chk("t6_rr_reset", 128'(mst_req_ready), 128'(2'b01));
    chk("t6_rr_valid", 128'(slv_req_valid), 128'(1));
    cyc();
    mst_req_valid = 2'b00;
    #1;
    chk("t6_cnt_after", 128'(outstd_cnt), 128'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
